// File: rtl/bus_ram_responder_pkg.sv
// Shared types and lane helpers for the CPU data-bus RAM responder.
package bus_ram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_resp_state_t;

    localparam int BYTE_LANES = 4;
    localparam int DATA_BITS  = 8 * BYTE_LANES;

    // Reads never write: a read cycle collapses every lane enable to zero.
    function automatic logic [BYTE_LANES-1:0] lane_write_enables(
        input logic                  we_l,
        input logic [BYTE_LANES-1:0] be
    );
        return we_l ? '0 : be;
    endfunction

    function automatic logic [DATA_BITS-1:0] lane_mask(input logic [BYTE_LANES-1:0] be);
        logic [DATA_BITS-1:0] mask;
        for (int k = 0; k < BYTE_LANES; k++) begin
            mask[8*k +: 8] = {8{be[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/bus_ram_responder_if.sv
// CPU data-bus signal bundle seen by the RAM responder.
interface bus_ram_responder_if;
    import bus_ram_responder_pkg::*;

    logic                  AS_L;
    logic                  WE_L;
    logic [31:0]           Address;
    logic [BYTE_LANES-1:0] Byte_Enable;
    logic [DATA_BITS-1:0]  Wr_Data;
    logic [DATA_BITS-1:0]  Rd_Data;
    logic                  DTAck;
    logic                  Hit;

    modport master (
        output AS_L, WE_L, Address, Byte_Enable, Wr_Data,
        input  Rd_Data, DTAck, Hit
    );

    modport slave (
        input  AS_L, WE_L, Address, Byte_Enable, Wr_Data,
        output Rd_Data, DTAck, Hit
    );
endinterface

// File: rtl/bus_ram_responder_array.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
module bus_ram_array
    import bus_ram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BYTE_LANES-1:0] we,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_BITS-1:0]  wdata,
    output logic [DATA_BITS-1:0]  rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        for (int k = 0; k < BYTE_LANES; k++) begin
            if (we[k]) begin
                mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Only the read register is reset; it doubles as the bus read-data holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_ram_responder.sv
// Bus target for the CPU data bus: decodes the address window, waits, then performs one
// byte-laned RAM access and holds DTAck until the CPU releases AS_L.
module bus_ram_responder
    import bus_ram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_STATES = 1
) (
    input  logic             Clock,
    input  logic             Reset_L,
    bus_ram_responder_if.slave bus
);

    localparam int CNT_BITS = 5;
    // The counter includes the access edge itself, so DTAck always follows WAIT_STATES+1 edges after capture.
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(WAIT_STATES + 1);

    bus_resp_state_t state, state_next;
    logic [CNT_BITS-1:0]   wait_cnt, wait_cnt_next;
    logic [ADDR_BITS-1:0]  cap_index;
    logic                  cap_we_l;
    logic [BYTE_LANES-1:0] cap_be;
    logic [DATA_BITS-1:0]  cap_wdata;
    logic                  hit;
    logic                  capture;
    logic                  access;
    logic [BYTE_LANES-1:0] ram_we;
    logic                  ram_re;
    logic                  unused_addr_bits;

    assign hit              = !bus.AS_L && (bus.Address[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign bus.Hit          = hit;
    assign bus.DTAck        = (state == ACK);
    assign unused_addr_bits = ^bus.Address[1:0];

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next state; "access" fires exactly once, on the edge that moves WAIT into ACK.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        access        = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    capture       = 1'b1;
                    wait_cnt_next = CNT_LOAD;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (bus.AS_L) begin
                    wait_cnt_next = '0;
                    state_next    = IDLE;
                end else if (wait_cnt == CNT_BITS'(1)) begin
                    access        = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = ACK;
                end else begin
                    wait_cnt_next = wait_cnt - CNT_BITS'(1);
                end
            end
            ACK: begin
                if (bus.AS_L) begin
                    state_next = IDLE;
                end
            end
            default: begin
                wait_cnt_next = '0;
                state_next    = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            cap_index <= '0;
            cap_we_l  <= 1'b1;
            cap_be    <= '0;
            cap_wdata <= '0;
        end else if (capture) begin
            cap_index <= bus.Address[ADDR_BITS+1:2];
            cap_we_l  <= bus.WE_L;
            cap_be    <= bus.Byte_Enable;
            cap_wdata <= bus.Wr_Data;
        end
    end

    assign ram_we = access ? lane_write_enables(cap_we_l, cap_be) : '0;
    assign ram_re = access && cap_we_l;

    bus_ram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (Clock),
        .rst_n (Reset_L),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cap_index),
        .wdata (cap_wdata),
        .rdata (bus.Rd_Data)
    );

endmodule

// File: tb/tb_bus_ram_responder.sv
// Randomized scoreboard bench for bus_ram_responder: one instance with 1 wait state, one with 3.
module tb_bus_ram_responder;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic Clock = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 Clock = ~Clock;

    bus_ram_responder_if bus_a();
    bus_ram_responder_if bus_b();

    bus_ram_responder #(.BASE_ADDR(BASE), .ADDR_BITS(8), .WAIT_STATES(1)) dut (
        .Clock   (Clock),
        .Reset_L (rst_a),
        .bus     (bus_a)
    );

    bus_ram_responder #(.BASE_ADDR(BASE), .ADDR_BITS(8), .WAIT_STATES(3)) dut_w3 (
        .Clock   (Clock),
        .Reset_L (rst_b),
        .bus     (bus_b)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [0:255];
    logic [31:0] model_rd = 32'h0;
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        prev_ack = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word, input logic [31:0] new_word,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_word[8*k +: 8];
        end
        return r;
    endfunction

    // Monitor: every rising DTAck on bus A must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (bus_a.DTAck && !prev_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack: got DTAck=1, expected no transaction");
            end else begin
                check_output(name_q.pop_front(), bus_a.Rd_Data, exp_q.pop_front());
            end
        end
        prev_ack = bus_a.DTAck;
    end

    task automatic apply_stimulus(input logic we_l, input logic [31:0] addr, input logic [3:0] be,
                                  input logic [31:0] data, input string name);
        int   edges;
        int   high_cnt;
        logic in_win;
        logic [7:0] idx;
        in_win = (addr >= BASE) && (addr < BASE + 32'd1024);
        idx    = addr[9:2];
        @(negedge Clock);
        bus_a.AS_L        = 1'b0;
        bus_a.WE_L        = we_l;
        bus_a.Address     = addr;
        bus_a.Byte_Enable = be;
        bus_a.Wr_Data     = data;
        #1 check_output({name, " hit"}, 32'(bus_a.Hit), 32'(in_win));
        if (in_win) begin
            if (!we_l) model_mem[idx] = merge_bytes(model_mem[idx], data, be);
            else       model_rd = model_mem[idx];
            exp_q.push_back(model_rd);
            name_q.push_back({name, " rd_data"});
            edges = 0;
            do begin
                @(negedge Clock);
                edges++;
                bus_a.Address = ~addr;
                bus_a.Wr_Data = ~data;
            end while (!bus_a.DTAck && edges < 40);
            check_output({name, " latency"}, 32'(edges), 32'd3);
            bus_a.AS_L = 1'b1;
            @(negedge Clock);
            check_output({name, " dtack_low"}, 32'(bus_a.DTAck), 32'd0);
        end else begin
            high_cnt = 0;
            repeat (20) begin
                @(negedge Clock);
                if (bus_a.DTAck) high_cnt++;
            end
            check_output({name, " no_dtack"}, 32'(high_cnt), 32'd0);
            bus_a.AS_L = 1'b1;
        end
    endtask

    task automatic b_issue(input logic we_l, input logic [31:0] addr, input logic [31:0] data);
        @(negedge Clock);
        bus_b.AS_L        = 1'b0;
        bus_b.WE_L        = we_l;
        bus_b.Address     = addr;
        bus_b.Byte_Enable = 4'hF;
        bus_b.Wr_Data     = data;
    endtask

    task automatic b_wait_ack(output int edges);
        edges = 0;
        do begin
            @(negedge Clock);
            edges++;
        end while (!bus_b.DTAck && edges < 40);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int held;
        logic [31:0] addr;

        bus_a.AS_L = 1'b1; bus_a.WE_L = 1'b1; bus_a.Address = '0; bus_a.Byte_Enable = '0; bus_a.Wr_Data = '0;
        bus_b.AS_L = 1'b1; bus_b.WE_L = 1'b1; bus_b.Address = '0; bus_b.Byte_Enable = '0; bus_b.Wr_Data = '0;

        #3 rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check_output("reset dtack_a", 32'(bus_a.DTAck), 32'd0);
        check_output("reset rd_a", bus_a.Rd_Data, 32'd0);
        check_output("reset dtack_b", 32'(bus_b.DTAck), 32'd0);
        check_output("reset rd_b", bus_b.Rd_Data, 32'd0);
        repeat (2) @(negedge Clock);
        rst_a = 1'b1; rst_b = 1'b1;

        for (int w = 0; w < 16; w++) begin
            apply_stimulus(1'b0, BASE + 32'(4*w), 4'hF, $urandom, "init");
        end
        apply_stimulus(1'b0, BASE + 32'h3FC, 4'hF, $urandom, "init_top");

        apply_stimulus(1'b0, 32'h0000_1004, 4'hF, 32'hDEADBEEF, "wr_1004");
        apply_stimulus(1'b1, 32'h0000_1004, 4'hF, 32'h0, "rd_1004");
        check_output("const deadbeef", bus_a.Rd_Data, 32'hDEADBEEF);

        apply_stimulus(1'b0, 32'h0000_1008, 4'hF, 32'h11223344, "pre_1008");
        apply_stimulus(1'b0, 32'h0000_1008, 4'b1000, 32'hAABBCCDD, "be1000");
        apply_stimulus(1'b1, 32'h0000_1008, 4'b0001, 32'h0, "rd_be1000");
        check_output("const aa223344", bus_a.Rd_Data, 32'hAA223344);
        apply_stimulus(1'b0, 32'h0000_1008, 4'b0011, 32'h0000_5566, "be0011");
        apply_stimulus(1'b1, 32'h0000_1008, 4'hF, 32'h0, "rd_be0011");
        check_output("const aa225566", bus_a.Rd_Data, 32'hAA225566);
        apply_stimulus(1'b0, 32'h0000_1008, 4'b0000, 32'hFFFF_FFFF, "be0000");
        apply_stimulus(1'b1, 32'h0000_1008, 4'hF, 32'h0, "rd_be0000");
        check_output("const unchanged", bus_a.Rd_Data, 32'hAA225566);

        apply_stimulus(1'b0, 32'h0000_0FFC, 4'hF, 32'h5A5A5A5A, "miss_low");
        apply_stimulus(1'b0, 32'h0000_1400, 4'hF, 32'hA5A5A5A5, "miss_high");
        apply_stimulus(1'b1, BASE + 32'h3FC, 4'hF, 32'h0, "rd_word255");
        apply_stimulus(1'b1, BASE, 4'hF, 32'h0, "rd_word0");

        // Asynchronous reset while bus A is holding an acknowledged read.
        @(negedge Clock);
        bus_a.AS_L = 1'b0; bus_a.WE_L = 1'b1; bus_a.Address = 32'h0000_1004; bus_a.Byte_Enable = 4'hF;
        model_rd = model_mem[1];
        exp_q.push_back(model_rd);
        name_q.push_back("pre_reset rd_data");
        lat = 0;
        do begin @(negedge Clock); lat++; end while (!bus_a.DTAck && lat < 40);
        check_output("pre_reset latency", 32'(lat), 32'd3);
        #2 rst_a = 1'b0;
        #1;
        check_output("midcycle reset dtack", 32'(bus_a.DTAck), 32'd0);
        check_output("midcycle reset rd", bus_a.Rd_Data, 32'd0);
        bus_a.AS_L = 1'b1;
        model_rd = 32'h0;
        @(negedge Clock);
        rst_a = 1'b1;

        for (int i = 0; i < 60; i++) begin
            addr = BASE + 32'(4 * $urandom_range(15, 0));
            apply_stimulus(1'($urandom_range(1, 0)), addr, 4'($urandom_range(15, 0)), $urandom, "rand");
        end

        // Bus B: three wait states, abort and reset during WAIT, long ACK hold.
        b_issue(1'b0, 32'h0000_100C, 32'h12345678);
        b_wait_ack(lat);
        check_output("w3 latency", 32'(lat), 32'd5);
        bus_b.AS_L = 1'b1;
        @(negedge Clock);
        check_output("w3 dtack_low", 32'(bus_b.DTAck), 32'd0);

        b_issue(1'b0, 32'h0000_100C, 32'hCAFEF00D);
        @(negedge Clock);
        bus_b.AS_L = 1'b1;
        held = 0;
        repeat (6) begin
            @(negedge Clock);
            if (bus_b.DTAck) held++;
        end
        check_output("abort no_dtack", 32'(held), 32'd0);
        b_issue(1'b1, 32'h0000_100C, 32'h0);
        b_wait_ack(lat);
        check_output("abort latency", 32'(lat), 32'd5);
        check_output("abort ram", bus_b.Rd_Data, 32'h12345678);
        bus_b.AS_L = 1'b1;

        b_issue(1'b0, 32'h0000_100C, 32'h0BADBAD0);
        repeat (2) @(negedge Clock);
        #2 rst_b = 1'b0;
        #1;
        check_output("wait reset dtack", 32'(bus_b.DTAck), 32'd0);
        check_output("wait reset rd", bus_b.Rd_Data, 32'd0);
        bus_b.AS_L = 1'b1;
        @(negedge Clock);
        rst_b = 1'b1;
        repeat (6) @(negedge Clock);

        b_issue(1'b1, 32'h0000_100C, 32'h0);
        b_wait_ack(lat);
        check_output("reset ram", bus_b.Rd_Data, 32'h12345678);
        held = 0;
        repeat (5) begin
            @(negedge Clock);
            if (bus_b.DTAck && bus_b.Rd_Data === 32'h12345678) held++;
        end
        check_output("ack hold cycles", 32'(held), 32'd5);
        bus_b.AS_L = 1'b1;
        @(negedge Clock);
        check_output("ack hold release", 32'(bus_b.DTAck), 32'd0);

        repeat (3) @(negedge Clock);
        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
